// File: rtl/signed_mont_reduce_if.sv
// Streaming interface for signed_mont_reduce.
//   in_valid  : operand a is valid this cycle (producer -> reducer)
//   a         : signed IN_W-bit operand
//   out_valid : result is valid this cycle (reducer -> consumer)
//   result    : signed OUT_W-bit reduced value
// There is no backpressure; the consumer must accept every valid result.
interface signed_mont_reduce_if #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 16
);
  logic                    in_valid;
  logic signed [IN_W-1:0]  a;
  logic                    out_valid;
  logic signed [OUT_W-1:0] result;

  modport master (
    output in_valid,
    output a,
    input  out_valid,
    input  result
  );

  modport slave (
    input  in_valid,
    input  a,
    output out_valid,
    output result
  );
endinterface

// File: rtl/signed_mont_reduce.sv
// Pipelined signed Montgomery reduction (Kyber, q = 3329, R = 2^16).
// Computes result = a * R^-1 mod q, bit-exact with the Kyber reference
// montgomery_reduce:
//   t      = int16(a[15:0] * QINV)
//   result = (a - t*Q) >>> 16, wrapped to OUT_W bits
// For |a| < Q*2^15 the result lies in (-Q, Q); larger inputs wrap silently.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, clears all valid and data registers
//   bus   : signed_mont_reduce_if slave (in_valid, a in; out_valid, result out)
//
// Build option:
//   MONT_REDUCE_PIPE_EN : when defined, registers (t, a) between the first
//   multiply and the t*Q subtract, giving latency 2 instead of 1. Results
//   are identical in both builds.
module signed_mont_reduce #(
  parameter int unsigned Q     = 3329,
  parameter int unsigned QINV  = 62209,
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 16
) (
  input logic                clk,
  input logic                rst_n,
  signed_mont_reduce_if.slave bus
);

  // Wide enough that a - t*Q can never overflow.
  localparam int unsigned DW = IN_W + OUT_W + 2;

  localparam logic [OUT_W-1:0]     QINV_L = OUT_W'(QINV);
  localparam logic signed [DW-1:0] Q_EXT  = DW'(Q);

  // First multiply: only the low OUT_W bits of the product are needed.
  logic [OUT_W-1:0] t_c;
  always_comb begin
    t_c = bus.a[OUT_W-1:0] * QINV_L;
  end

  // Operands feeding the subtract/shift stage.
  logic                    red_valid;
  logic signed [IN_W-1:0]  red_a;
  logic        [OUT_W-1:0] red_t;

`ifdef MONT_REDUCE_PIPE_EN
  logic                    s1_valid_q;
  logic signed [IN_W-1:0]  s1_a_q;
  logic        [OUT_W-1:0] s1_t_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_t_q     <= '0;
    end else begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a_q <= bus.a;
        s1_t_q <= t_c;
      end
    end
  end

  always_comb begin
    red_valid = s1_valid_q;
    red_a     = s1_a_q;
    red_t     = s1_t_q;
  end
`else
  always_comb begin
    red_valid = bus.in_valid;
    red_a     = bus.a;
    red_t     = t_c;
  end
`endif

  // Second multiply and subtract, done at DW bits with sign extension.
  logic signed [DW-1:0] a_ext;
  logic signed [DW-1:0] t_ext;
  logic signed [DW-1:0] tq;
  logic signed [DW-1:0] d;

  always_comb begin
    a_ext = {{(DW-IN_W){red_a[IN_W-1]}}, red_a};
    t_ext = {{(DW-OUT_W){red_t[OUT_W-1]}}, red_t};
    tq    = t_ext * Q_EXT;
    d     = a_ext - tq;
  end

  // d is a multiple of 2^OUT_W by construction, so the low bits are always
  // zero; bits above 2*OUT_W are dropped by the two's-complement wrap.
  logic unused_d_bits;
  assign unused_d_bits = ^{d[DW-1:2*OUT_W], d[OUT_W-1:0]};

  logic                    out_valid_q;
  logic signed [OUT_W-1:0] result_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      out_valid_q <= red_valid;
      if (red_valid) begin
        result_q <= d[2*OUT_W-1:OUT_W];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_signed_mont_reduce.sv
// Self-checking bench for signed_mont_reduce. A behavioural model computes
// the Kyber montgomery_reduce with integer arithmetic and delays it by the
// build's latency; every cycle the DUT outputs are compared with it.
module tb_signed_mont_reduce;

`ifdef MONT_REDUCE_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam longint QM    = 3329;
  localparam longint RANGE = 3329 * 32768;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  signed_mont_reduce_if bus ();

  signed_mont_reduce dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    bit     v;
    longint a;
  } item_t;

  item_t              pipe_q[$];
  bit                 exp_ov  = 1'b0;
  logic signed [15:0] exp_res = '0;
  longint             exp_a   = 0;

  // Kyber montgomery_reduce in plain integer arithmetic.
  function automatic logic signed [15:0] ref_mont(input longint a);
    longint lo, t, d, r;
    lo = ((a % 65536) + 65536) % 65536;
    t  = (lo * 62209) % 65536;
    if (t >= 32768) t = t - 65536;
    d = a - t * QM;
    r = d / 65536;
    return 16'(r);
  endfunction

  // Apply one cycle of stimulus and advance the model at the clock edge.
  task automatic drive(input bit v, input longint av, input bit rn);
    item_t it;
    bus.in_valid = v;
    bus.a        = 32'(av);
    rst_n        = rn;
    @(posedge clk);
    if (!rn) begin
      pipe_q.delete();
      for (int i = 0; i < LAT - 1; i++) pipe_q.push_back('{v: 1'b0, a: 0});
      exp_ov  = 1'b0;
      exp_res = '0;
    end else begin
      pipe_q.push_back('{v: v, a: av});
      it     = pipe_q.pop_front();
      exp_ov = it.v;
      if (it.v) begin
        exp_res = ref_mont(it.a);
        exp_a   = it.a;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    int cyc;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5000, 1'b0);
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.result !== 16'sd0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: out_valid=%b result=%0d, need 0/0",
                 i, bus.out_valid, bus.result);
      end
    end
    drive(1'b1, 5000, 1'b1);
    cyc = 1;
    while (bus.out_valid !== 1'b1 && cyc < 10) begin
      drive(1'b0, 0, 1'b1);
      cyc++;
    end
    n_cmp++;
    if (cyc != LAT || bus.result !== -16'sd566) begin
      n_fail++;
      $display("FAIL reset_first_out: latency=%0d result=%0d, need %0d/-566",
               cyc, bus.result, LAT);
    end
    drive(1'b0, 0, 1'b1);
    for (int i = 0; i < LAT; i++) drive(1'b0, 0, 1'b1);
  endtask

  task automatic test_values(input string name, input longint av[], input int ev[]);
    for (int k = 0; k < av.size(); k++) begin
      drive(1'b1, av[k], 1'b1);
      for (int i = 0; i < LAT - 1; i++) begin
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_early a=%0d: out_valid=%b, need 0", name, av[k], bus.out_valid);
        end
        drive(1'b0, 0, 1'b1);
      end
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.result !== 16'(ev[k])) begin
        n_fail++;
        $display("FAIL %s a=%0d: out_valid=%b result=%0d, need 1/%0d",
                 name, av[k], bus.out_valid, bus.result, ev[k]);
      end
      drive(1'b0, 0, 1'b1);
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.result !== 16'(ev[k])) begin
        n_fail++;
        $display("FAIL %s_hold a=%0d: out_valid=%b result=%0d, need 0/%0d",
                 name, av[k], bus.out_valid, bus.result, ev[k]);
      end
    end
  endtask

  task automatic test_small();
    longint av[] = '{0, 1, 65536, 5000, -5000};
    int     ev[] = '{0, 169, 1, -566, 566};
    test_values("small", av, ev);
  endtask

  task automatic test_large();
    longint av[] = '{1234567890, -1234567890};
    int     ev[] = '{17683, -17683};
    test_values("large", av, ev);
  endtask

  task automatic test_back_to_back();
    longint av[] = '{5000, -5000, 1, 65536};
    int     ev[] = '{-566, 566, 169, 1};
    int     got[$];
    int     first, last;
    first = -1;
    last  = -1;
    for (int c = 0; c < 4 + LAT + 2; c++) begin
      if (c < 4) drive(1'b1, av[c], 1'b1);
      else       drive(1'b0, 0, 1'b1);
      n_cmp++;
      if (bus.out_valid !== exp_ov || bus.result !== exp_res) begin
        n_fail++;
        $display("FAIL b2b_model cyc%0d: out_valid=%b result=%0d, need %b/%0d",
                 c, bus.out_valid, bus.result, exp_ov, exp_res);
      end
      if (bus.out_valid === 1'b1) begin
        got.push_back(int'(bus.result));
        if (first < 0) first = c;
        last = c;
      end
    end
    n_cmp++;
    if (got.size() != 4 || first != LAT - 1 || last != LAT + 2) begin
      n_fail++;
      $display("FAIL b2b_burst: count=%0d first=%0d last=%0d, need 4/%0d/%0d",
               got.size(), first, last, LAT - 1, LAT + 2);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (got[i] != ev[i]) begin
          n_fail++;
          $display("FAIL b2b_value%0d: result=%0d, need %0d", i, got[i], ev[i]);
        end
      end
    end
    n_cmp++;
    if (bus.result !== 16'sd1) begin
      n_fail++;
      $display("FAIL b2b_hold: result=%0d, need 1", bus.result);
    end
  endtask

  task automatic test_sweep();
    longint av, m;
    bit     v;
    for (int c = 0; c < 400; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      av = longint'($urandom_range(0, 32'(2 * RANGE - 2))) - (RANGE - 1);
      drive(v, av, 1'b1);
      n_cmp++;
      if (bus.out_valid !== exp_ov || bus.result !== exp_res) begin
        n_fail++;
        $display("FAIL sweep_model cyc%0d: out_valid=%b result=%0d, need %b/%0d",
                 c, bus.out_valid, bus.result, exp_ov, exp_res);
      end
      if (exp_ov) begin
        m = (longint'(bus.result) * 65536 - exp_a) % QM;
        n_cmp++;
        if (bus.result <= -16'sd3329 || bus.result >= 16'sd3329 || m != 0) begin
          n_fail++;
          $display("FAIL sweep_range a=%0d: result=%0d residue=%0d, need |r|<3329 and 0",
                   exp_a, bus.result, m);
        end
      end
    end
    for (int i = 0; i < LAT; i++) drive(1'b0, 0, 1'b1);
  endtask

  task automatic test_midreset();
    drive(1'b1, 1234567, 1'b1);
    if (LAT > 1) begin
      // Operand is now inside the pipeline stage.
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_pre: out_valid=%b, need 0", bus.out_valid);
      end
    end
    drive(1'b1, 7777, 1'b0);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.result !== 16'sd0) begin
      n_fail++;
      $display("FAIL midreset_clear: out_valid=%b result=%0d, need 0/0",
               bus.out_valid, bus.result);
    end
    for (int c = 0; c < LAT + 3; c++) begin
      drive(1'b0, 0, 1'b1);
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.result !== 16'sd0) begin
        n_fail++;
        $display("FAIL midreset_stale cyc%0d: out_valid=%b result=%0d, need 0/0",
                 c, bus.out_valid, bus.result);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.a        = '0;
    test_reset();
    test_small();
    test_large();
    test_back_to_back();
    test_sweep();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/signed_mont_reduce.md
Name: signed_mont_reduce

Overview:
Pipelined signed Montgomery reduction for Kyber NTT arithmetic (q = 3329, R = 2^16).
- Takes a signed 32-bit product a and returns a·R^-1 mod q as a signed 16-bit value.
- For the nominal input range, the result lies in (-q, q).
- Sits after the butterfly multiplier in the NTT/INTT datapath.
- Streaming block with valid qualifier; no backpressure.

Parameters:
- Q, 3329, modulus.
- QINV, 62209, q^-1 mod 2^16 (equals -3327 as int16).
- IN_W, 32, input width (signed).
- OUT_W, 16, output width (signed); Montgomery R = 2^OUT_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  a is valid this cycle.
- a  input  IN_W  signed operand to reduce.
- out_valid  output  1  result is valid this cycle.
- result  output  OUT_W  signed reduced value.

Behaviour:
- Reset (rst_n low at a clk edge):
  - result = 0, out_valid = 0, all pipeline valid bits cleared.
  - Data registers are also cleared to 0.
- Arithmetic, bit-exact with the Kyber reference montgomery_reduce:
  - t = low 16 bits of (a[15:0] * QINV), interpreted as signed int16.
  - d = a - t*Q, computed at ≥ 34 bits signed. No intermediate overflow is permitted.
  - d is always divisible by 2^16. result = d >>> 16 (arithmetic), truncated to OUT_W bits (two's-complement wrap).
- Range:
  - |a| < Q·2^15 guarantees -Q < result < Q.
  - Out-of-range inputs still follow the same formula with wrap; no saturation and no error flag.
- Base latency is 1 cycle:
  - Inputs are sampled at edge N; result and out_valid are registered and update at edge N.
  - Both are visible one cycle after presentation.
- Throughput: one operand per cycle, fully pipelined.
- out_valid equals in_valid delayed by the latency.
- result updates only when the corresponding valid is 1; otherwise it holds its last value.
- Reset mid-stream: all in-flight operands are discarded and out_valid = 0 the cycle after reset.
  - Operands presented while rst_n is low are ignored.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: MONT_REDUCE_PIPE_EN.
- Defined:
  - An extra register stage is inserted between the t computation (first multiply) and the t·Q subtract/shift (second multiply). The registered t and a are carried together.
  - Latency = 2 cycles. Throughput is still 1 per cycle.
  - Reset clears the extra stage, including its valid bit.
- Undefined: single-stage design, latency 1.
- Result values are identical in both builds; only timing differs.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with in_valid=1, a=5000 -> out_valid=0, result=0 throughout. After rst_n=1, the first valid output appears after the configured latency.
2. Small values: a=0 -> 0; a=1 -> 169; a=65536 -> 1; a=5000 -> -566; a=-5000 -> 566. Each accompanies out_valid=1 exactly latency cycles after in_valid.
3. Large values: a=1234567890 -> 17683; a=-1234567890 -> -17683. Exact formula, no saturation.
4. Back-to-back streaming:
   - Stimulus: in_valid=1 for consecutive cycles with a = 5000, -5000, 1, 65536, then in_valid=0.
   - Response: out_valid high for 4 consecutive cycles with results -566, 566, 169, 1, then low. result holds 1 afterwards.
5. Range/congruence sweep:
   - Stimulus: random a with |a| < 3329·2^15.
   - Response: -3329 < result < 3329, and (result·65536 - a) mod 3329 == 0.
   - Run in both MONT_REDUCE_PIPE_EN builds; check latency 1 and 2 respectively.
6. Mid-stream reset: assert rst_n=0 while an operand is in flight -> the next cycle shows out_valid=0 and result=0; no stale result ever emerges.
